// File: rtl/sched_pkg.sv
// Shared types and constants for the channel frame scheduler.
package sched_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CFG  = 3'd1,
        RUN  = 3'd2,
        TAIL = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam int CH_IDX_W    = 4;
    localparam int THR_W       = 16;
    localparam int RUN_LEN_DEF = 134;

    // Width of the shared RUN/GAP down-counter
    localparam int CNT_W = 16;

endpackage

// File: rtl/threshold_regfile.sv
// Host-writable per-channel noise threshold table, 16 entries of THR_W bits.
// Writes to indices at or above N_CH are dropped; the read port is combinational
// so the arbiter can register the selected channel's entry on the grant edge.
module threshold_regfile
    import sched_pkg::*;
#(
    parameter int N_CH = 8
) (
    input  logic                clk_25m,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_addr,
    input  logic [THR_W-1:0]    wr_data,
    input  logic [CH_IDX_W-1:0] rd_addr,
    output logic [THR_W-1:0]    rd_data
);

    localparam logic [CH_IDX_W:0] N_CH_W = (CH_IDX_W+1)'(N_CH);

    logic [THR_W-1:0] regs [16];

    // Table storage: cleared by reset, one host write per cycle
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < N_CH_W)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Combinational read of the entry the arbiter is currently selecting
    always_comb begin
        rd_data = regs[rd_addr];
    end

endmodule

// File: rtl/channel_frame_scheduler.sv
// Round-robin frame scheduler: grants one requesting channel at a time, strobes
// its threshold into the conditioning stage, then opens a RUN_LEN-cycle data
// window, a one-cycle trailer and a GAP_LEN-cycle idle gap.
//
// Request/grant semantics: ch_req is a level held by each channel while it has a
// frame ready; it is sampled only in IDLE. ch_grant is one-hot and held from CFG
// through TAIL; dropping ch_req while granted does not abort the frame.
module channel_frame_scheduler
    import sched_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int GAP_LEN = 2
) (
    input  logic                clk_25m,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [N_CH-1:0]     ch_req,
    input  logic                thr_wr_en,
    input  logic [CH_IDX_W-1:0] thr_wr_addr,
    input  logic [THR_W-1:0]    thr_wr_data,
    output logic [N_CH-1:0]     ch_grant,
    output logic [CH_IDX_W-1:0] channel_number,
    output logic                para_cofi_flag,
    output logic [THR_W-1:0]    noise_threshold,
    output logic                data_flag,
    output logic                frame_done,
    output logic                busy
);

    localparam logic [CH_IDX_W:0]   N_CH_W   = (CH_IDX_W+1)'(N_CH);
    localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]    RUN_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST = CNT_W'(GAP_LEN - 1);

    state_t              state;
    logic [CH_IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0]    cnt;

    logic [2*N_CH-1:0]   req_dbl;
    logic [N_CH-1:0]     req_rot;
    logic [CH_IDX_W:0]   sel_off;
    logic [CH_IDX_W:0]   sel_sum;
    logic [CH_IDX_W-1:0] sel_idx;
    logic [N_CH-1:0]     sel_onehot;
    logic [THR_W-1:0]    sel_thr;

    threshold_regfile #(
        .N_CH (N_CH)
    ) u_thr (
        .clk_25m (clk_25m),
        .rst_n   (rst_n),
        .wr_en   (thr_wr_en),
        .wr_addr (thr_wr_addr),
        .wr_data (thr_wr_data),
        .rd_addr (sel_idx),
        .rd_data (sel_thr)
    );

    // Round-robin picker: rotate requests so rr_ptr sits at bit 0, take the
    // lowest set bit, then rotate the offset back into a channel index
    always_comb begin
        req_dbl = {ch_req, ch_req} >> rr_ptr;
        req_rot = req_dbl[N_CH-1:0];
        sel_off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_off = i[CH_IDX_W:0];
            end
        end
        sel_sum = {1'b0, rr_ptr} + sel_off;
        if (sel_sum >= N_CH_W) begin
            sel_sum = sel_sum - N_CH_W;
        end
        sel_idx = sel_sum[CH_IDX_W-1:0];
        sel_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_onehot[i] = (sel_idx == i[CH_IDX_W-1:0]);
        end
    end

    // Frame sequencer with registered outputs and a shared RUN/GAP down-counter
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            cnt             <= '0;
            ch_grant        <= '0;
            channel_number  <= '0;
            para_cofi_flag  <= 1'b0;
            noise_threshold <= '0;
            data_flag       <= 1'b0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && (|ch_req)) begin
                        ch_grant        <= sel_onehot;
                        channel_number  <= sel_idx;
                        noise_threshold <= sel_thr;
                        para_cofi_flag  <= 1'b1;
                        busy            <= 1'b1;
                        state           <= CFG;
                    end
                end
                CFG: begin
                    para_cofi_flag <= 1'b0;
                    data_flag      <= 1'b1;
                    cnt            <= RUN_LAST;
                    state          <= RUN;
                end
                RUN: begin
                    if (cnt == '0) begin
                        data_flag  <= 1'b0;
                        frame_done <= 1'b1;
                        rr_ptr     <= (channel_number == LAST_CH) ? '0 : channel_number + 1'b1;
                        state      <= TAIL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TAIL: begin
                    frame_done <= 1'b0;
                    ch_grant   <= '0;
                    cnt        <= GAP_LAST;
                    state      <= GAP;
                end
                GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_frame_scheduler.sv
// Directed bench for channel_frame_scheduler (N_CH=8, RUN_LEN=134, GAP_LEN=2).
// Inputs are driven and outputs sampled on the falling edge of clk_25m.
module tb_channel_frame_scheduler;

    logic        clk_25m = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  ch_req = '0;
    logic        thr_wr_en = 1'b0;
    logic [3:0]  thr_wr_addr = '0;
    logic [15:0] thr_wr_data = '0;
    logic [7:0]  ch_grant;
    logic [3:0]  channel_number;
    logic        para_cofi_flag;
    logic [15:0] noise_threshold;
    logic        data_flag;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    channel_frame_scheduler #(
        .N_CH    (8),
        .RUN_LEN (134),
        .GAP_LEN (2)
    ) dut (
        .clk_25m         (clk_25m),
        .rst_n           (rst_n),
        .enable          (enable),
        .ch_req          (ch_req),
        .thr_wr_en       (thr_wr_en),
        .thr_wr_addr     (thr_wr_addr),
        .thr_wr_data     (thr_wr_data),
        .ch_grant        (ch_grant),
        .channel_number  (channel_number),
        .para_cofi_flag  (para_cofi_flag),
        .noise_threshold (noise_threshold),
        .data_flag       (data_flag),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    // Clock and reset
    always #20 clk_25m = ~clk_25m;

    task automatic apply_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        ch_req      = '0;
        thr_wr_en   = 1'b0;
        thr_wr_addr = '0;
        thr_wr_data = '0;
        repeat (2) @(negedge clk_25m);
        rst_n = 1'b1;
    endtask

    // Driver: one host threshold write, occupying one cycle
    task automatic write_thr(input logic [3:0] addr, input logic [15:0] data);
        thr_wr_en   = 1'b1;
        thr_wr_addr = addr;
        thr_wr_data = data;
        @(negedge clk_25m);
        thr_wr_en = 1'b0;
    endtask

    // Advance until para_cofi_flag is seen or the budget runs out
    task automatic wait_cfg(input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_25m);
            cycles++;
        end while (para_cofi_flag !== 1'b1 && cycles < max_cycles);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk_25m);
        checks++;
        if ({ch_grant, channel_number, para_cofi_flag, noise_threshold, data_flag, frame_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%h ch=%0d cofi=%b thr=%h data=%b done=%b busy=%b, expected all 0",
                     ch_grant, channel_number, para_cofi_flag, noise_threshold, data_flag, frame_done, busy);
        end
        apply_reset();
        @(negedge clk_25m);
        checks++;
        if (busy !== 1'b0 || ch_grant !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b grant=%h, expected 0 and 00", busy, ch_grant);
        end
    endtask

    task automatic test_threshold_load();
        int cyc;
        int n;
        bit grant_bad;
        apply_reset();
        write_thr(4'd3, 16'h0100);
        ch_req = 8'h08;
        enable = 1'b1;
        wait_cfg(5, cyc);
        ch_req = 8'h00;
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL load_latency: got %0d cycles, expected 1", cyc);
        end
        checks++;
        if (para_cofi_flag !== 1'b1 || noise_threshold !== 16'h0100 || channel_number !== 4'd3 ||
            ch_grant !== 8'h08 || busy !== 1'b1 || data_flag !== 1'b0) begin
            errors++;
            $display("FAIL load_cfg: got cofi=%b thr=%h ch=%0d grant=%h busy=%b data=%b, expected 1 0100 3 08 1 0",
                     para_cofi_flag, noise_threshold, channel_number, ch_grant, busy, data_flag);
        end
        n = 0;
        grant_bad = 1'b0;
        @(negedge clk_25m);
        while (data_flag === 1'b1 && n < 200) begin
            if (ch_grant !== 8'h08 || para_cofi_flag !== 1'b0) grant_bad = 1'b1;
            n++;
            @(negedge clk_25m);
        end
        checks++;
        if (n !== 134) begin
            errors++;
            $display("FAIL load_run_len: got %0d data cycles, expected 134", n);
        end
        checks++;
        if (grant_bad !== 1'b0) begin
            errors++;
            $display("FAIL load_run_grant: got grant drop or cofi during RUN, expected grant=08 cofi=0");
        end
        checks++;
        if (frame_done !== 1'b1 || ch_grant !== 8'h08 || data_flag !== 1'b0) begin
            errors++;
            $display("FAIL load_tail: got done=%b grant=%h data=%b, expected 1 08 0", frame_done, ch_grant, data_flag);
        end
        @(negedge clk_25m);
        checks++;
        if (frame_done !== 1'b0 || ch_grant !== 8'h00 || busy !== 1'b1 ||
            channel_number !== 4'd3 || noise_threshold !== 16'h0100) begin
            errors++;
            $display("FAIL load_gap: got done=%b grant=%h busy=%b ch=%0d thr=%h, expected 0 00 1 3 0100",
                     frame_done, ch_grant, busy, channel_number, noise_threshold);
        end
        repeat (2) @(negedge clk_25m);
        checks++;
        if (busy !== 1'b0 || channel_number !== 4'd3 || noise_threshold !== 16'h0100) begin
            errors++;
            $display("FAIL load_idle_hold: got busy=%b ch=%0d thr=%h, expected 0 3 0100", busy, channel_number, noise_threshold);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        int exp_ch;
        apply_reset();
        ch_req = 8'hFF;
        enable = 1'b1;
        wait_cfg(5, cyc);
        for (int f = 0; f < 9; f++) begin
            exp_ch = f % 8;
            if (f > 0) begin
                wait_cfg(200, cyc);
                checks++;
                if (cyc !== 139) begin
                    errors++;
                    $display("FAIL rr_period frame %0d: got %0d cycles, expected 139", f, cyc);
                end
            end
            checks++;
            if (para_cofi_flag !== 1'b1 || channel_number !== exp_ch[3:0] || ch_grant !== (8'h01 << exp_ch)) begin
                errors++;
                $display("FAIL rr_order frame %0d: got cofi=%b ch=%0d grant=%h, expected 1 %0d %h",
                         f, para_cofi_flag, channel_number, ch_grant, exp_ch, 8'h01 << exp_ch);
            end
        end
        enable = 1'b0;
        ch_req = 8'h00;
    endtask

    task automatic test_wrap_skip();
        int cyc;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'd5;
        exp_seq[1] = 4'd0;
        exp_seq[2] = 4'd2;
        exp_seq[3] = 4'd0;
        apply_reset();
        ch_req = 8'h20;
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_cfg(200, cyc);
            if (f == 0) ch_req = 8'h05;
            checks++;
            if (para_cofi_flag !== 1'b1 || channel_number !== exp_seq[f]) begin
                errors++;
                $display("FAIL wrap_skip grant %0d: got cofi=%b ch=%0d, expected 1 %0d", f, para_cofi_flag, channel_number, exp_seq[f]);
            end
        end
        enable = 1'b0;
        ch_req = 8'h00;
    endtask

    task automatic test_write_collision();
        int cyc;
        apply_reset();
        write_thr(4'd1, 16'h0050);
        ch_req      = 8'h02;
        enable      = 1'b1;
        thr_wr_en   = 1'b1;
        thr_wr_addr = 4'd1;
        thr_wr_data = 16'h0200;
        wait_cfg(5, cyc);
        thr_wr_en = 1'b0;
        checks++;
        if (para_cofi_flag !== 1'b1 || channel_number !== 4'd1 || noise_threshold !== 16'h0050) begin
            errors++;
            $display("FAIL collision_old: got cofi=%b ch=%0d thr=%h, expected 1 1 0050", para_cofi_flag, channel_number, noise_threshold);
        end
        wait_cfg(200, cyc);
        checks++;
        if (para_cofi_flag !== 1'b1 || channel_number !== 4'd1 || noise_threshold !== 16'h0200) begin
            errors++;
            $display("FAIL collision_new: got cofi=%b ch=%0d thr=%h, expected 1 1 0200", para_cofi_flag, channel_number, noise_threshold);
        end
        enable = 1'b0;
        ch_req = 8'h00;
    endtask

    task automatic test_enable_drop();
        int cyc;
        bit idle_bad;
        apply_reset();
        write_thr(4'd9, 16'hBEEF);
        ch_req = 8'hFF;
        enable = 1'b1;
        wait_cfg(5, cyc);
        checks++;
        if (noise_threshold !== 16'h0000 || channel_number !== 4'd0) begin
            errors++;
            $display("FAIL ignored_write: got thr=%h ch=%0d, expected 0000 0", noise_threshold, channel_number);
        end
        repeat (10) @(negedge clk_25m);
        enable = 1'b0;
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 200) begin
            @(negedge clk_25m);
            cyc++;
        end
        checks++;
        if (frame_done !== 1'b1 || cyc !== 125) begin
            errors++;
            $display("FAIL enable_drop_done: got done=%b after %0d cycles, expected 1 after 125", frame_done, cyc);
        end
        repeat (2) @(negedge clk_25m);
        checks++;
        if (busy !== 1'b1 || ch_grant !== 8'h00 || data_flag !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_gap: got busy=%b grant=%h data=%b, expected 1 00 0", busy, ch_grant, data_flag);
        end
        idle_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_25m);
            if (busy !== 1'b0 || ch_grant !== 8'h00 || para_cofi_flag !== 1'b0) idle_bad = 1'b1;
        end
        checks++;
        if (idle_bad !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_idle: got activity while disabled, expected busy=0 grant=00");
        end
        ch_req = 8'h00;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        apply_reset();
        write_thr(4'd2, 16'h0AAA);
        ch_req = 8'h04;
        enable = 1'b1;
        wait_cfg(5, cyc);
        checks++;
        if (noise_threshold !== 16'h0AAA) begin
            errors++;
            $display("FAIL pre_reset_thr: got %h, expected 0AAA", noise_threshold);
        end
        repeat (60) @(negedge clk_25m);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ch_grant, channel_number, para_cofi_flag, noise_threshold, data_flag, frame_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got grant=%h ch=%0d cofi=%b thr=%h data=%b done=%b busy=%b, expected all 0",
                     ch_grant, channel_number, para_cofi_flag, noise_threshold, data_flag, frame_done, busy);
        end
        @(negedge clk_25m);
        rst_n = 1'b1;
        wait_cfg(5, cyc);
        checks++;
        if (cyc !== 1 || para_cofi_flag !== 1'b1 || channel_number !== 4'd2 || noise_threshold !== 16'h0000) begin
            errors++;
            $display("FAIL reset_restart: got cyc=%0d cofi=%b ch=%0d thr=%h, expected 1 1 2 0000",
                     cyc, para_cofi_flag, channel_number, noise_threshold);
        end
        enable = 1'b0;
        ch_req = 8'h00;
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_threshold_load();
        test_round_robin();
        test_wrap_skip();
        test_write_collision();
        test_enable_drop();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
